if_fetch_unit: RTL



---
 rtl/cpu_pkg.sv | 19 +
 rtl/if_sync_fifo.sv | 54 +++++
 rtl/if_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch constants, fetch FSM state.
package cpu_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic {
    FS_RUN,
    FS_DRAIN
  } fetch_state_e;

  // One buffered fetch result: the instruction word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count. DEPTH must be a power of 2.
module if_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Pop only real entries; a push into a full FIFO is fine when the head leaves the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

  // Pointer and occupancy bookkeeping; flush discards everything held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, no reset needed since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests,
// stale-response discard after redirect, and an in-order instruction buffer.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] PC_o,
  output logic [31:0] PC_next_o
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   CREDITS = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding, outstanding_nxt, discard;
  logic [CW-1:0]   buf_count, tag_count;
  fetch_state_e    state;
  logic            in_drain, accept, keep_word;
  logic            buf_push, buf_pop, buf_empty, tag_empty;
  fetch_entry_t    buf_in, buf_head;
  logic [XLEN-1:0] tag_head;
  logic            unused_tag;

  // Credits cover both buffered and in-flight words so the buffer can never overflow.
  assign imem_req_o  = !rst_i && !redirect_i &&
                       (({1'b0, buf_count} + {1'b0, outstanding}) < CREDITS);
  assign imem_addr_o = fetch_pc;
  assign accept      = imem_req_o && imem_ready_i;

  assign in_drain        = (state == FS_DRAIN);
  assign keep_word       = imem_rvalid_i && !in_drain;
  assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rvalid_i);

  // A word returning in a redirect cycle belongs to the old path and is dropped.
  assign buf_push = keep_word && !redirect_i;
  assign buf_pop  = valid_o && !stall_i && !redirect_i;
  assign buf_in   = '{instr: imem_rdata_i, pc: tag_head};

  assign valid_o   = !buf_empty;
  assign instr_o   = valid_o ? buf_head.instr : INSTR_NOP;
  assign PC_o      = valid_o ? buf_head.pc : '0;
  assign PC_next_o = valid_o ? (buf_head.pc + PC_STEP) : '0;

  // Tag queue occupancy is implied by outstanding/discard; keep it for debug only.
  assign unused_tag = ^{tag_count, tag_empty};

  // Fetch PC, in-flight count and the RUN/DRAIN discard tracker.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      state       <= FS_RUN;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        // No issue happens this cycle, so everything still due after it is stale.
        fetch_pc <= redirect_pc_i & ~32'h3;
        discard  <= outstanding_nxt;
        state    <= (outstanding_nxt != '0) ? FS_DRAIN : FS_RUN;
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_STEP;
        if (imem_rvalid_i && in_drain) begin
          discard <= discard - CW'(1);
          state   <= (discard == CW'(1)) ? FS_RUN : FS_DRAIN;
        end
      end
    end
  end

  if_sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_instr_buf (
    .clk  (clk_i),
    .rst  (rst_i),
    .flush(redirect_i),
    .push (buf_push),
    .din  (buf_in),
    .pop  (buf_pop),
    .dout (buf_head),
    .empty(buf_empty),
    .count(buf_count)
  );

  // Addresses of live in-flight requests, consumed in order as their words return.
  if_sync_fifo #(
    .WIDTH(XLEN),
    .DEPTH(FIFO_DEPTH)
  ) u_tag_q (
    .clk  (clk_i),
    .rst  (rst_i),
    .flush(redirect_i),
    .push (accept),
    .din  (fetch_pc),
    .pop  (keep_word),
    .dout (tag_head),
    .empty(tag_empty),
    .count(tag_count)
  );

endmodule
